key_step_gen: RTL and testbench

KEY_STEP_GEN -- requirements
Module: key_step_gen

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce.sv | 43 ++++
 rtl/key_step_gen.sv | 142 ++++++++++++++
 tb/tb_key_step_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key step generator: per-key FSM state encoding
// and default timing constants.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RPT   = 2'd2,
    ST_BLOCK = 2'd3
  } key_state_t;

  localparam int DEF_DEB_CYC    = 16;
  localparam int DEF_RPT_DELAY  = 500;
  localparam int DEF_RPT_PERIOD = 100;
  localparam int DEF_RPT_EN     = 1;

  // Larger of two integers, used to size the shared repeat counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw key input: 2-flop synchronizer, consecutive-mismatch counter and the
// debounced level it drives. The level flips only after DEB_CYC consecutive
// edges at which the synchronized input disagrees with it.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
)(
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int DW = $clog2(DEB_CYC);
  localparam logic [DW-1:0] LAST = DW'(DEB_CYC - 1);

  logic [1:0]    sync;
  logic [DW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], raw};
  end

  // Count disagreeing edges; any agreeing edge restarts the count. The count
  // is cleared when it reaches its last value, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_step_gen.sv
// Turns the up/down buttons into one-cycle step requests for a number
// selector: a press pulse, then optional auto-repeat while the key is held.
// Holding both keys blocks all pulses until each key is individually released.
module key_step_gen
  import key_pkg::*;
#(
  parameter int DEB_CYC    = DEF_DEB_CYC,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int RPT_EN     = DEF_RPT_EN
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_raw,
  input  logic       key_dn_raw,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       up_held,
  output logic       dn_held,
  output key_state_t up_state,
  output key_state_t dn_state
);

  localparam int CW = $clog2(max2(RPT_DELAY, RPT_PERIOD));
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);

  // Index 0 is the up key, index 1 the down key.
  logic [1:0]    held;
  logic [1:0]    fire;
  logic          both_held;
  key_state_t    st_q  [2];
  key_state_t    st_d  [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  key_debounce #(.DEB_CYC(DEB_CYC)) u_up_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_up_raw),
    .level (held[0])
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_dn_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_dn_raw),
    .level (held[1])
  );

  // Per-key next state, repeat counter and pulse request. A key can only fire
  // while its own level is high, so forcing BLOCK when both are high also
  // guarantees the two pulses are never high together.
  always_comb begin
    both_held = held[0] & held[1];
    fire      = 2'b00;
    for (int k = 0; k < 2; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
      unique case (st_q[k])
        ST_IDLE: begin
          if (held[k]) begin
            st_d[k]  = ST_WAIT;
            cnt_d[k] = '0;
            fire[k]  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (!held[k]) begin
            st_d[k]  = ST_IDLE;
            cnt_d[k] = '0;
          end else if (cnt_q[k] == DLY_LAST) begin
            // Without auto-repeat the counter parks here until release.
            if (RPT_EN != 0) begin
              st_d[k]  = ST_RPT;
              cnt_d[k] = '0;
              fire[k]  = 1'b1;
            end
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        ST_RPT: begin
          if (!held[k]) begin
            st_d[k]  = ST_IDLE;
            cnt_d[k] = '0;
          end else if (cnt_q[k] == PER_LAST) begin
            cnt_d[k] = '0;
            fire[k]  = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        ST_BLOCK: begin
          cnt_d[k] = '0;
          if (!held[k]) st_d[k] = ST_IDLE;
        end
        default: begin
          st_d[k]  = ST_IDLE;
          cnt_d[k] = '0;
        end
      endcase
      if (both_held) begin
        st_d[k]  = ST_BLOCK;
        cnt_d[k] = '0;
        fire[k]  = 1'b0;
      end
    end
  end

  // State and counter registers for both keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]  <= ST_IDLE;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Registered step pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      inc_pulse <= fire[0];
      dec_pulse <= fire[1];
    end
  end

  assign up_held  = held[0];
  assign dn_held  = held[1];
  assign up_state = st_q[0];
  assign dn_state = st_q[1];

endmodule

// File: tb/tb_key_step_gen.sv
// Directed bench for key_step_gen. Two instances share the key inputs: one with
// auto-repeat enabled and one with it disabled. Expected outputs per cycle come
// from press/release timing (debounce latency, repeat delay and period).
module tb_key_step_gen;
  import key_pkg::*;

  localparam int DEB    = 4;
  localparam int DELAY  = 20;
  localparam int PERIOD = 8;
  localparam int BIG    = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_up_raw = 1'b0;
  logic key_dn_raw = 1'b0;

  logic inc0, dec0, uh0, dh0, inc1, dec1, uh1, dh1;
  key_state_t us0, ds0, us1, ds1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit in_rst   = 1'b1;

  // Window in which each debounced level is expected high.
  int up_on = -1, up_off = BIG;
  int dn_on = -1, dn_off = BIG;

  // Expected pulse cycles: 0 inc rpt, 1 dec rpt, 2 inc single, 3 dec single.
  int pl0[$], pl1[$], pl2[$], pl3[$];

  logic [7:0] exp_q[$];

  key_step_gen #(.DEB_CYC(DEB), .RPT_DELAY(DELAY), .RPT_PERIOD(PERIOD), .RPT_EN(1)) dut_rep (
    .clk(clk), .rst_n(rst_n), .key_up_raw(key_up_raw), .key_dn_raw(key_dn_raw),
    .inc_pulse(inc0), .dec_pulse(dec0), .up_held(uh0), .dn_held(dh0),
    .up_state(us0), .dn_state(ds0)
  );

  key_step_gen #(.DEB_CYC(DEB), .RPT_DELAY(DELAY), .RPT_PERIOD(PERIOD), .RPT_EN(0)) dut_one (
    .clk(clk), .rst_n(rst_n), .key_up_raw(key_up_raw), .key_dn_raw(key_dn_raw),
    .inc_pulse(inc1), .dec_pulse(dec1), .up_held(uh1), .dn_held(dh1),
    .up_state(us1), .dn_state(ds1)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic bit hit(input int w, input int c);
    bit r;
    r = 1'b0;
    case (w)
      0: foreach (pl0[i]) if (pl0[i] == c) r = 1'b1;
      1: foreach (pl1[i]) if (pl1[i] == c) r = 1'b1;
      2: foreach (pl2[i]) if (pl2[i] == c) r = 1'b1;
      default: foreach (pl3[i]) if (pl3[i] == c) r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic bit win(input int on, input int off, input int c);
    return (on >= 0) && (c >= on + DEB + 1) && (c < off + DEB + 1);
  endfunction

  task automatic push_pulse(input int w, input int c);
    case (w)
      0: pl0.push_back(c);
      1: pl1.push_back(c);
      2: pl2.push_back(c);
      default: pl3.push_back(c);
    endcase
  endtask

  // Press pulse DEB+2 edges after the press edge, then repeats; only edges
  // before 'stop' can carry a pulse.
  task automatic add_rep(input int w, input int a, input int stop, input bit en);
    int t;
    t = a + DEB + 2;
    if (t < stop) push_pulse(w, t);
    if (en) begin
      t = t + DELAY;
      while (t < stop) begin
        push_pulse(w, t);
        t = t + PERIOD;
      end
    end
  endtask

  // One clock: push expectation for the coming edge, then pop and compare.
  task automatic step();
    logic [7:0] e, got;
    int c;
    bit uh, dh;
    c  = cyc + 1;
    uh = win(up_on, up_off, c);
    dh = win(dn_on, dn_off, c);
    e  = in_rst ? 8'h00 : {hit(0, c), hit(1, c), hit(2, c), hit(3, c), uh, dh, uh, dh};
    exp_q.push_back(e);
    @(posedge clk);
    cyc++;
    #1;
    got = {inc0, dec0, inc1, dec1, uh0, dh0, uh1, dh1};
    e = exp_q.pop_front();
    n_checks++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL outputs@cyc%0d observed=%b expected=%b", cyc, got, e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Press a key; when predict is set, pulses for a hold of 'hold' cycles are queued.
  task automatic press(input int key, input int hold, input bit predict);
    int a;
    a = cyc + 1;
    if (key == 0) begin
      key_up_raw = 1'b1; up_on = a; up_off = BIG;
    end else begin
      key_dn_raw = 1'b1; dn_on = a; dn_off = BIG;
    end
    if (predict) begin
      add_rep(key, a, a + hold + DEB + 2, 1'b1);
      add_rep(key + 2, a, a + hold + DEB + 2, 1'b0);
    end
  endtask

  task automatic release_key(input int key);
    if (key == 0) begin
      key_up_raw = 1'b0; up_off = cyc + 1;
    end else begin
      key_dn_raw = 1'b0; dn_off = cyc + 1;
    end
  endtask

  task automatic check_states(input string tag, input key_state_t eu, input key_state_t ed);
    n_checks++;
    assert ({us0, ds0, us1, ds1} === {eu, ed, eu, ed}) else begin
      n_fail++;
      $error("FAIL %s observed=%0d/%0d/%0d/%0d expected=%0d/%0d", tag, us0, ds0, us1, ds1, eu, ed);
    end
  endtask

  initial begin
    int a;
    // Reset
    run(3);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    check_states("reset_states", ST_IDLE, ST_IDLE);
    run(5);

    // Short press of up: single pulse at offset 7.
    press(0, 10, 1'b1);
    run(10);
    release_key(0);
    run(15);

    // Bouncing down key: never accepted.
    for (int i = 0; i < 8; i++) begin
      key_dn_raw = 1'b1; run(2);
      key_dn_raw = 1'b0; run(2);
    end
    run(10);

    // Long hold of up: press plus repeats (single pulse with repeat off).
    press(0, 60, 1'b1);
    run(60);
    release_key(0);
    run(15);

    // Long hold of down: same pattern on dec_pulse.
    press(1, 40, 1'b1);
    run(40);
    release_key(1);
    run(15);

    // Both keys held: blocked, and down stays blocked after up is released.
    press(0, 0, 1'b0);
    a = up_on;
    push_pulse(0, a + DEB + 2);
    push_pulse(2, a + DEB + 2);
    run(10);
    press(1, 0, 1'b0);
    run(20);
    check_states("block_both", ST_BLOCK, ST_BLOCK);
    release_key(0);
    run(40);
    check_states("block_dn_only", ST_IDLE, ST_BLOCK);
    release_key(1);
    run(15);
    check_states("block_exit", ST_IDLE, ST_IDLE);

    // Reset in the middle of a repeat while up stays held.
    press(0, 0, 1'b0);
    a = up_on;
    add_rep(0, a, a + 29, 1'b1);
    add_rep(2, a, a + 29, 1'b0);
    run(29);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    up_on  = -1;
    #1;
    n_checks++;
    assert ({inc0, dec0, uh0, dh0, inc1, dec1, uh1, dh1} === 8'h00) else begin
      n_fail++;
      $error("FAIL async_reset observed=%b expected=%b",
             {inc0, dec0, uh0, dh0, inc1, dec1, uh1, dh1}, 8'h00);
    end
    check_states("async_reset_states", ST_IDLE, ST_IDLE);
    run(3);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    press(0, 30, 1'b1);
    run(30);
    release_key(0);
    run(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
